// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M MUL/DIV sequencer sharing one 33-bit ripple adder.
// Define MULDIV_EARLY_OUT_EN to bypass the datapath when rs2 is zero.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [2:0] {
    IDLE, NEG_A, NEG_B, ITER, FIX_LO, FIX_HI, DONE
  } state_t;

  state_t state, state_nx;

  logic [XLEN-1:0] hi, lo, b, result_q;
  logic [2:0]      f3;
  logic [4:0]      cnt;
  logic            neg_a, neg_b, cy, done_q;
  logic            sgn_a, sgn_b, accept, is_div, sel_hi;

  logic [XLEN:0]   add_a, add_b, add_s;
  logic            add_ci, add_co;

  assign accept = (state == IDLE) && start_i && !flush_i;
  assign is_div = f3[2];
  assign sel_hi = f3[2] ? f3[1] : (f3[1:0] != 2'b00);

  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    unique case (funct3_i)
      3'b001, 3'b100, 3'b110: begin
        sgn_a = 1'b1;
        sgn_b = 1'b1;
      end
      3'b010:  sgn_a = 1'b1;
      default: ;
    endcase
  end

  // Single ripple-carry adder built from full-adder cells.
  always_comb begin : rca
    logic c;
    c = add_ci;
    for (int i = 0; i <= XLEN; i++) begin
      add_s[i] = add_a[i] ^ add_b[i] ^ c;
      c = (add_a[i] & add_b[i]) | (c & (add_a[i] ^ add_b[i]));
    end
    add_co = c;
  end

  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    unique case (state)
      NEG_A: begin
        add_a  = {1'b0, ~lo};
        add_ci = 1'b1;
      end
      NEG_B: begin
        add_a  = {1'b0, ~b};
        add_ci = 1'b1;
      end
      ITER: begin
        if (is_div) begin
          add_a  = {hi, lo[XLEN-1]};
          add_b  = {1'b1, ~b};
          add_ci = 1'b1;
        end else begin
          add_a = {1'b0, hi};
          add_b = lo[0] ? {1'b0, b} : '0;
        end
      end
      FIX_LO: begin
        add_a  = {1'b0, ~lo};
        add_ci = 1'b1;
      end
      FIX_HI: begin
        add_a  = {1'b0, ~hi};
        add_ci = is_div ? 1'b1 : cy;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = NEG_A;
`ifdef MULDIV_EARLY_OUT_EN
          if (rs2_i == '0) state_nx = DONE;
`endif
        end
      end
      NEG_A:   state_nx = NEG_B;
      NEG_B:   state_nx = ITER;
      ITER:    if (cnt == 5'(XLEN-1)) state_nx = FIX_LO;
      FIX_LO:  state_nx = FIX_HI;
      FIX_HI:  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush_i && state != IDLE) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi       <= '0;
      lo       <= '0;
      b        <= '0;
      f3       <= '0;
      cnt      <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      cy       <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= (state == DONE) && !flush_i;
      unique case (state)
        IDLE: begin
          if (accept) begin
            f3    <= funct3_i;
            lo    <= rs1_i;
            hi    <= '0;
            b     <= rs2_i;
            cnt   <= '0;
            cy    <= 1'b0;
            neg_a <= sgn_a & rs1_i[XLEN-1];
            neg_b <= sgn_b & rs2_i[XLEN-1];
`ifdef MULDIV_EARLY_OUT_EN
            // Preload the RV32M zero-operand answers for DONE to select.
            if (rs2_i == '0) begin
              lo <= funct3_i[2] ? '1 : '0;
              hi <= funct3_i[2] ? rs1_i : '0;
            end
`endif
          end
        end
        NEG_A: if (neg_a) lo <= add_s[XLEN-1:0];
        NEG_B: if (neg_b) b <= add_s[XLEN-1:0];
        ITER: begin
          cnt <= cnt + 5'd1;
          if (is_div) begin
            lo <= {lo[XLEN-2:0], add_co};
            hi <= add_co ? add_s[XLEN-1:0] : add_a[XLEN-1:0];
          end else begin
            hi <= add_s[XLEN:1];
            lo <= {add_s[0], lo[XLEN-1:1]};
          end
        end
        FIX_LO: begin
          if (is_div) begin
            if ((neg_a ^ neg_b) && b != '0) lo <= add_s[XLEN-1:0];
          end else if (neg_a ^ neg_b) begin
            lo <= add_s[XLEN-1:0];
            cy <= add_s[XLEN];
          end
        end
        FIX_HI: begin
          if (is_div ? neg_a : (neg_a ^ neg_b)) hi <= add_s[XLEN-1:0];
        end
        DONE: if (!flush_i) result_q <= sel_hi ? hi : lo;
        default: ;
      endcase
    end
  end

  assign busy_o   = (state != IDLE);
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller for the RV32M MUL/DIV family in the EX stage.
- Time-shares one 33-bit ripple adder, built from full-adder cells, for operand negation, shift-add multiply, restoring divide and result sign fix-up.
- Talks to the pipeline with a start/busy/done handshake.
- The hazard unit stalls the pipeline while busy_o is high.

Parameters:
- XLEN, 32, operand and result width. Only 32 is supported. Iteration count equals XLEN.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- flush_i  input  1  abort the current operation.
- start_i  input  1  launch request; sampled only in IDLE.
- funct3_i  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_i  input  XLEN  dividend / multiplicand.
- rs2_i  input  XLEN  divisor / multiplier.
- busy_o  output  1  high in every state except IDLE.
- done_o  output  1  one-cycle pulse; result_o is valid in that cycle.
- result_o  output  XLEN  result; held until the next accepted start.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - busy_o=0, done_o=0, result_o=0.
  - All datapath registers (HI, LO, B, sign flags, counter) cleared to 0.
- States: IDLE -> NEG_A -> NEG_B -> ITER -> FIX_LO -> FIX_HI -> DONE -> IDLE.
- IDLE:
  - On start_i=1 and flush_i=0: latch funct3, rs1 to LO, rs2 to B, counter=0.
  - Derive the signed flags: MULH, MULHSU (rs1 only), DIV and REM are signed.
- NEG_A: if rs1 is signed and negative, LO = ~LO + 1 through the shared adder (Cin=1).
- NEG_B: same for B.
- Both NEG states are always traversed, so latency is fixed.
- ITER runs 32 cycles; the counter increments each cycle and leaves at 31.
  - Multiply:
    - sum{c,s} = HI + (LO[0] ? B : 0).
    - {HI,LO} = {c,s,LO} >> 1.
  - Divide (restoring):
    - {HI,LO} shifted left 1.
    - trial = HI_shifted + ~B + 1.
    - If carry-out=1: HI=trial[31:0], LO[0]=1. Else LO[0]=0.
- FIX_LO:
  - Multiply: if the operand signs differ, LO = ~LO + 1; keep the carry-out.
  - Divide: negate the quotient when the signs differ AND the divisor is nonzero.
- FIX_HI:
  - Multiply with signs differing: HI = ~HI + saved carry.
  - Divide: negate the remainder if the dividend was negative.
- DONE:
  - result_o = LO for MUL/DIV/DIVU, HI for MULH*/REM/REMU.
  - done_o=1 for exactly this cycle; next state IDLE.
- Latency: start sampled at edge E0, done_o high after edge E37. Fixed at 37 cycles for every funct3 and every operand.
- Corner cases follow the RV32M spec without special datapath:
  - x/0: quotient 0xFFFFFFFF, remainder = rs1.
  - 0x80000000 / -1: quotient 0x80000000, remainder 0.
- start_i while busy_o=1 is ignored. It is not queued.
- flush_i=1 in any non-IDLE state:
  - Next state is IDLE; done_o stays 0.
  - result_o keeps its previous value.
- flush_i and start_i both high in IDLE: flush wins, start is ignored.
- Reset mid-operation: immediate return to the reset values above. No done_o.
- Adder use: exactly one adder instance. Its operand mux is selected by state.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - If rs2_i==0 when start is accepted, IDLE goes straight to DONE.
  - Result: MUL* = 0, DIV/DIVU = 0xFFFFFFFF, REM/REMU = rs1_i.
  - done_o is high after edge E1.
- Undefined: no bypass; a zero divisor or multiplier takes the full 37 cycles.

Test Plan:
- MUL rs1=7, rs2=6 -> done_o at E37, result_o=0x0000002A; busy_o high E1..E37.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7%2 -> 0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV -5/0 -> 0xFFFFFFFF.
  - Without the macro: done_o at E37.
  - With MULDIV_EARLY_OUT_EN: done_o at E1.
- Flush at E10 of a DIV, then start MUL 3*3 at E12 -> no done_o for the DIV; done_o at E12+37 with result 9. A start_i pulse during busy is ignored.
- rst_n low at E20 of a MUL -> busy_o, done_o, result_o all 0 asynchronously. A new start after release completes normally.
